// File: rtl/hash_enc_pkg.sv
// Shared types and constants for the hash-encoding front end: FSM states,
// spatial-hash primes and the corner-index bit mapping.
package hash_enc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORNER,
        S_FETCH,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [31:0] PRIME_X = 32'd1;
    localparam logic [31:0] PRIME_Y = 32'd2654435761;
    localparam logic [31:0] PRIME_Z = 32'd805459861;

    // Corner index bit that selects the +1 neighbour along x, and the
    // bits that select the lower neighbour along y and z.
    localparam int X_HI_BIT = 0;
    localparam int Y_LO_BIT = 1;
    localparam int Z_LO_BIT = 2;

    localparam int NUM_CORNERS   = 8;
    localparam int DEF_DATA_SIZE = 32;
    localparam int DEF_FRAC_BITS = 16;
    localparam int DEF_LOG2_T    = 14;

endpackage

// File: rtl/grid_corner_fetch_hash.sv
// Combinational spatial hash of one integer grid corner into a
// feature-table index.
module grid_hash
    import hash_enc_pkg::*;
#(
    parameter int INT_W  = 16,
    parameter int LOG2_T = DEF_LOG2_T
) (
    input  logic [INT_W-1:0]  ix,
    input  logic [INT_W-1:0]  iy,
    input  logic [INT_W-1:0]  iz,
    output logic [LOG2_T-1:0] idx
);

    logic [31:0] h;
    logic        unused_hi;

    // Products are truncated to 32 bits before mixing.
    assign h         = (32'(ix) * PRIME_X) ^ (32'(iy) * PRIME_Y) ^ (32'(iz) * PRIME_Z);
    assign idx       = h[LOG2_T-1:0];
    assign unused_hi = ^h[31:LOG2_T];

endmodule

// File: rtl/grid_corner_fetch.sv
// Derives the 8 voxel corners around a sample point, fetches their hashed
// features from the table SRAM and hands everything to the interpolator.
module grid_corner_fetch
    import hash_enc_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int LOG2_T    = DEF_LOG2_T
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_SIZE-1:0]       px,
    input  logic [DATA_SIZE-1:0]       py,
    input  logic [DATA_SIZE-1:0]       pz,
    output logic                       mem_rd_en,
    output logic [LOG2_T-1:0]          mem_rd_addr,
    input  logic [DATA_SIZE-1:0]       mem_rd_data,
    output logic [0:7][DATA_SIZE-1:0]  feat,
    output logic [0:8][DATA_SIZE-1:0]  x,
    output logic [0:8][DATA_SIZE-1:0]  y,
    output logic [0:8][DATA_SIZE-1:0]  z,
    output logic                       en,
    input  logic                       done
);

    localparam int INT_W = DATA_SIZE - FRAC_BITS;
    localparam logic [DATA_SIZE-1:0] ONE      = DATA_SIZE'(1) << FRAC_BITS;
    localparam logic [DATA_SIZE-1:0] INT_MASK = ~(ONE - DATA_SIZE'(1));

    state_t state, state_n;
    logic [2:0] k;
    logic       drain;
    logic       rd_vld;
    logic [2:0] rd_idx;

    logic [DATA_SIZE-1:0] base_x, base_y, base_z;
    logic [0:7][DATA_SIZE-1:0] cx, cy, cz;
    logic [0:7][LOG2_T-1:0]    cidx, hash_q;

    assign base_x = x[8] & INT_MASK;
    assign base_y = y[8] & INT_MASK;
    assign base_z = z[8] & INT_MASK;

    // y and z take the upper neighbour when their select bit is clear, so
    // corners 0..1 sit above 2..3 in y and 0..3 above 4..7 in z.
    for (genvar i = 0; i < NUM_CORNERS; i++) begin : g_corner
        localparam bit X_HI = ((i >> X_HI_BIT) & 1) != 0;
        localparam bit Y_LO = ((i >> Y_LO_BIT) & 1) != 0;
        localparam bit Z_LO = ((i >> Z_LO_BIT) & 1) != 0;

        assign cx[i] = base_x + (X_HI ? ONE : '0);
        assign cy[i] = base_y + (Y_LO ? '0 : ONE);
        assign cz[i] = base_z + (Z_LO ? '0 : ONE);

        grid_hash #(.INT_W(INT_W), .LOG2_T(LOG2_T)) u_hash (
            .ix  (cx[i][DATA_SIZE-1:FRAC_BITS]),
            .iy  (cy[i][DATA_SIZE-1:FRAC_BITS]),
            .iz  (cz[i][DATA_SIZE-1:FRAC_BITS]),
            .idx (cidx[i])
        );
    end

    always_comb begin
        state_n     = state;
        in_ready    = 1'b0;
        en          = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        case (state)
            S_IDLE: begin
                in_ready = rstn;
                if (in_valid) state_n = S_CORNER;
            end
            S_CORNER: state_n = S_FETCH;
            S_FETCH: begin
                if (drain) begin
                    state_n = S_START;
                end else begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = hash_q[k];
                end
            end
            S_START: begin
                en      = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: if (done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            k      <= '0;
            drain  <= 1'b0;
            rd_vld <= 1'b0;
            rd_idx <= '0;
            hash_q <= '0;
            feat   <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
        end else begin
            state  <= state_n;
            rd_vld <= mem_rd_en;
            rd_idx <= k;
            // Read data trails its strobe by one cycle.
            if (rd_vld) feat[rd_idx] <= mem_rd_data;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x[8] <= px;
                        y[8] <= py;
                        z[8] <= pz;
                    end
                end
                S_CORNER: begin
                    for (int i = 0; i < NUM_CORNERS; i++) begin
                        x[i]      <= cx[i];
                        y[i]      <= cy[i];
                        z[i]      <= cz[i];
                        hash_q[i] <= cidx[i];
                    end
                    k     <= '0;
                    drain <= 1'b0;
                end
                S_FETCH: begin
                    if (!drain) begin
                        if (k == 3'd7) drain <= 1'b1;
                        else           k     <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_corner_fetch.sv
// Bench for grid_corner_fetch: timing-table reference model checked every
// cycle, plus directed literal checks and a randomized traffic phase.
module tb_grid_corner_fetch;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] IMSK = 32'hFFFF_0000;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       px = '0, py = '0, pz = '0;
    logic              mem_rd_en;
    logic [13:0]       mem_rd_addr;
    logic [31:0]       mem_rd_data = '0;
    logic [0:7][31:0]  feat;
    logic [0:8][31:0]  x, y, z;
    logic              en;
    logic              done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] salt = '0;

    grid_corner_fetch dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .px(px), .py(py), .pz(pz),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .feat(feat), .x(x), .y(y), .z(z), .en(en), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [13:0] a);
        return {18'b0, a} + 32'h100 + salt;
    endfunction

    function automatic logic [13:0] ref_hash(input logic [31:0] ix, iy, iz);
        logic [31:0] h;
        h = ix ^ (iy * 32'd2654435761) ^ (iz * 32'd805459861);
        return h[13:0];
    endfunction

    // One-cycle-latency table memory; junk when no read was issued.
    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? mem_fn(mem_rd_addr) : 32'hDEAD_BEEF;

    // Reference model: m_t is the cycle number since the accept edge.
    logic        m_busy = 1'b0;
    int          m_t = 0;
    logic [31:0] mx [0:8] = '{default: 0};
    logic [31:0] my [0:8] = '{default: 0};
    logic [31:0] mz [0:8] = '{default: 0};
    logic [31:0] mf [0:7] = '{default: 0};
    logic [13:0] mh [0:7] = '{default: 0};

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 1'b0;
            m_t = 0;
            for (int i = 0; i < 9; i++) begin mx[i] = 0; my[i] = 0; mz[i] = 0; end
            for (int i = 0; i < 8; i++) begin mf[i] = 0; mh[i] = 0; end
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_t = 1;
                mx[8] = px; my[8] = py; mz[8] = pz;
            end
        end else if (m_t >= 12 && done) begin
            m_busy = 1'b0;
        end else begin
            if (m_t == 1) begin
                for (int i = 0; i < 8; i++) begin
                    mx[i] = (mx[8] & IMSK) + (((i & 1) != 0) ? ONE : 32'h0);
                    my[i] = (my[8] & IMSK) + (((i & 2) != 0) ? 32'h0 : ONE);
                    mz[i] = (mz[8] & IMSK) + (((i & 4) != 0) ? 32'h0 : ONE);
                    mh[i] = ref_hash(mx[i] >> 16, my[i] >> 16, mz[i] >> 16);
                end
            end
            if (m_t >= 3 && m_t <= 10) mf[m_t-3] = mem_fn(mh[m_t-3]);
            m_t = m_t + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic e_rdy, e_en, e_rd, bad;
        logic [13:0] e_addr;
        e_rdy  = rstn && !m_busy;
        e_en   = m_busy && (m_t == 11);
        e_rd   = m_busy && (m_t >= 2) && (m_t <= 9);
        e_addr = e_rd ? mh[m_t-2] : 14'h0;
        checks++;
        if (in_ready !== e_rdy || en !== e_en || mem_rd_en !== e_rd || mem_rd_addr !== e_addr) begin
            failures++;
            $display("FAIL ctrl cyc=%0d got rdy=%b en=%b rd=%b addr=%h exp rdy=%b en=%b rd=%b addr=%h",
                     cyc, in_ready, en, mem_rd_en, mem_rd_addr, e_rdy, e_en, e_rd, e_addr);
        end
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!bad && (x[i] !== mx[i] || y[i] !== my[i] || z[i] !== mz[i])) begin
                bad = 1'b1;
                $display("FAIL coord cyc=%0d idx=%0d got %h/%h/%h exp %h/%h/%h",
                         cyc, i, x[i], y[i], z[i], mx[i], my[i], mz[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (!bad && feat[i] !== mf[i]) begin
                bad = 1'b1;
                $display("FAIL feat cyc=%0d idx=%0d got %h exp %h", cyc, i, feat[i], mf[i]);
            end
        end
        checks++;
        if (bad) failures++;
    end

    // Event monitor for the directed timing checks.
    int acc_cyc = 0, first_rd = -1, rd_cnt = 0, en_cyc = 0, prev_en = 0, en_cnt = 0;
    logic [13:0] first_addr = '0;
    always @(negedge clk) begin
        if (rstn && in_ready && in_valid) begin
            acc_cyc = cyc; rd_cnt = 0; first_rd = -1;
        end
        if (mem_rd_en) begin
            if (first_rd < 0) begin first_rd = cyc; first_addr = mem_rd_addr; end
            rd_cnt++;
        end
        if (en) begin prev_en = en_cyc; en_cyc = cyc; en_cnt++; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Accept one point, then return done `lag` cycles after en.
    task automatic run_txn(input logic [31:0] ax, ay, az, input int lag, input bit hold);
        int t0, rel;
        bit ok;
        px = ax; py = ay; pz = az; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout got in_ready=%b exp 1", in_ready);
        end
        t0 = cyc;
        step();
        if (!hold) in_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            rel = cyc - t0;
            done = (rel == 11 + lag);
            if (rel > 11 + lag) break;
            step();
        end
        done = 1'b0;
    endtask

    initial begin
        int en0;
        // Reset state
        step(); step(); step();
        chk("rst_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_en", {31'b0, en}, 32'h0);
        chk("rst_rd", {31'b0, mem_rd_en}, 32'h0);
        chk("rst_x8", x[8], 32'h0);
        chk("rst_feat7", feat[7], 32'h0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", {31'b0, in_ready}, 32'h1);

        // Point (1.25, 2.5, 3.75)
        en0 = en_cnt;
        run_txn(32'h0001_4000, 32'h0002_8000, 32'h0003_C000, 13, 1'b0);
        chk("x0", x[0], 32'h0001_0000);
        chk("x1", x[1], 32'h0002_0000);
        chk("y0", y[0], 32'h0003_0000);
        chk("y2", y[2], 32'h0002_0000);
        chk("z0", z[0], 32'h0004_0000);
        chk("z4", z[4], 32'h0003_0000);
        chk("x8", x[8], 32'h0001_4000);
        chk("addr0", {18'b0, first_addr}, 32'h3346);
        chk("feat0", feat[0], 32'h3446);
        chk("rd_pulses", rd_cnt, 8);
        chk("rd_start", first_rd - acc_cyc, 2);
        chk("en_cycle", en_cyc - acc_cyc, 11);
        chk("en_count", en_cnt - en0, 1);

        // Back-to-back with in_valid held high
        run_txn(32'h0005_1234, 32'h0007_0000, 32'h0009_FFFF, 12, 1'b1);
        run_txn(32'h000A_8000, 32'h0000_0001, 32'h00FF_0000, 12, 1'b0);
        chk("b2b_gap", en_cyc - prev_en, 24);

        // Max integer x wraps the +1 corner to zero
        run_txn(32'hFFFF_8000, 32'h1234_5678, 32'h0000_0001, 3, 1'b0);
        chk("wrap_x0", x[0], 32'hFFFF_0000);
        chk("wrap_x1", x[1], 32'h0000_0000);

        // Reset in the middle of FETCH
        en0 = en_cnt;
        px = 32'h0003_3333; py = 32'h0004_4444; pz = 32'h0005_5555; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 7; n++) step();
        chk("pre_rst_rd", {31'b0, mem_rd_en}, 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("abort_x8", x[8], 32'h0);
        chk("abort_x0", x[0], 32'h0);
        chk("abort_feat0", feat[0], 32'h0);
        chk("abort_rd", {31'b0, mem_rd_en}, 32'h0);
        chk("abort_en", {31'b0, en}, 32'h0);
        step();
        rstn = 1'b1;
        #1;
        chk("abort_ready", {31'b0, in_ready}, 32'h1);
        for (int n = 0; n < 15; n++) step();
        chk("abort_no_en", en_cnt - en0, 0);
        run_txn(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 5, 1'b0);
        chk("post_abort_en", en_cnt - en0, 1);

        // Randomized traffic with stray in_valid/done
        salt = $urandom;
        for (int n = 0; n < 1500; n++) begin
            step();
            in_valid = ($urandom_range(0, 2) == 0);
            px = ($urandom_range(0, 3) == 0) ? {16'hFFFF, 16'($urandom)} : $urandom;
            py = $urandom;
            pz = ($urandom_range(0, 3) == 0) ? {16'hFFFF, 16'($urandom)} : $urandom;
            done = ($urandom_range(0, 3) == 0);
        end
        step();
        in_valid = 1'b0;
        done = 1'b1;
        for (int n = 0; n < 20; n++) step();
        done = 1'b0;
        step();
        chk("final_idle", {31'b0, in_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
